// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: MEM-stage data-memory responder. It serves each 32-bit load
// or store as two 16-bit transfers on an external asynchronous SRAM. The low
// half-word is transferred first, then the high half-word.
//
// Optional feature: define SRAM_READ_BUFFER_EN to add a one-entry read buffer.
// A read that hits the buffer completes with a single freeze cycle and does
// not touch the SRAM.
//
// Parameters:
//   ADDR_BASE    - byte address mapped to SRAM word 0
//   PHASE_CYCLES - cycles per 16-bit transfer (1..7)
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   rd_en, wr_en        - load / store request, held by the pipeline until ready
//   address             - byte address (bits [1:0] ignored)
//   write_data          - store data
//   read_data           - load result, holds until the next completed read
//   ready               - combinational; low freezes the pipeline
//   SRAM_DQ             - bidirectional SRAM data bus
//   SRAM_ADDR           - SRAM half-word address
//   SRAM_WE_N/OE_N/CE_N/UB_N/LB_N - active-low SRAM controls
module mem_sram_ctrl #(
  parameter logic [31:0] ADDR_BASE    = 32'd1024,
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned WORD_W  = 17;
  localparam int unsigned PHASE_W = 3;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PHASE_W-1:0]   r_phase;
  logic [PHASE_W-1:0]   w_phase_nxt;
  logic                 r_is_wr;
  logic [WORD_W-1:0]    r_w;
  logic [31:0]          r_wdata;
  logic [15:0]          r_rd_lo;
  logic [31:0]          r_read_data;
  logic [17:0]          r_sram_addr;
  logic [15:0]          r_dq_out;
  logic                 r_dq_oe;
  logic                 r_we_n;
  logic                 r_oe_n;
  logic                 r_ce_n;

  logic [31:0]          w_offset;
  logic [WORD_W-1:0]    w_word;
  logic                 w_unused;
  logic                 w_start;
  logic                 w_buf_hit;
  logic                 w_last;
  logic                 w_is_wr_nxt;
  logic                 w_active_nxt;

  // Word index relative to the mapped base
  assign w_offset = address - ADDR_BASE;
  assign w_word   = w_offset[18:2];
  assign w_unused = &{1'b0, w_offset[31:19], w_offset[1:0]};

  assign w_last = (r_phase == LAST_PHASE);

`ifdef SRAM_READ_BUFFER_EN
  logic              r_buf_vld;
  logic [WORD_W-1:0] r_buf_w;
  logic [31:0]       r_buf_data;
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_start     = 1'b0;
    w_buf_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rd_en | wr_en) begin
          w_start     = 1'b1;
          w_phase_nxt = '0;
`ifdef SRAM_READ_BUFFER_EN
          w_buf_hit   = ~wr_en & r_buf_vld & (r_buf_w == w_word);
`endif
          w_state_nxt = w_buf_hit ? ST_DONE : ST_LO;
        end
      end
      ST_LO: begin
        if (w_last) begin
          w_state_nxt = ST_HI;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PHASE_W'(1);
        end
      end
      ST_HI: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PHASE_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // SRAM controls are registered from the next state so they move only on edges
  assign w_is_wr_nxt  = (r_state == ST_IDLE) ? wr_en : r_is_wr;
  assign w_active_nxt = (w_state_nxt == ST_LO) | (w_state_nxt == ST_HI);

  // State, request latch and SRAM interface registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_is_wr     <= 1'b0;
      r_w         <= '0;
      r_wdata     <= '0;
      r_rd_lo     <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_ce_n      <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_ce_n  <= ~w_active_nxt;
      r_we_n  <= ~(w_active_nxt & w_is_wr_nxt);
      r_oe_n  <= ~(w_active_nxt & ~w_is_wr_nxt);
      r_dq_oe <= w_active_nxt & w_is_wr_nxt;

      if (w_start) begin
        r_is_wr <= wr_en;
        r_w     <= w_word;
        r_wdata <= write_data;
      end

      if (r_state == ST_IDLE && w_state_nxt == ST_LO) begin
        r_sram_addr <= {w_word, 1'b0};
        r_dq_out    <= write_data[15:0];
      end else if (r_state == ST_LO && w_state_nxt == ST_HI) begin
        r_sram_addr <= {r_w, 1'b1};
        r_dq_out    <= r_wdata[31:16];
      end

      // Low half is staged so an abandoned read never leaks into read_data
      if (r_state == ST_LO && w_last && !r_is_wr) begin
        r_rd_lo <= SRAM_DQ;
      end

      if (r_state == ST_HI && w_last && !r_is_wr) begin
        r_read_data <= {SRAM_DQ, r_rd_lo};
      end
`ifdef SRAM_READ_BUFFER_EN
      else if (w_buf_hit) begin
        r_read_data <= r_buf_data;
      end
`endif
    end
  end

`ifdef SRAM_READ_BUFFER_EN
  // One-entry read buffer: filled by completed reads, kept coherent by writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_vld  <= 1'b0;
      r_buf_w    <= '0;
      r_buf_data <= '0;
    end else begin
      if (r_state == ST_HI && w_last && !r_is_wr) begin
        r_buf_vld  <= 1'b1;
        r_buf_w    <= r_w;
        r_buf_data <= {SRAM_DQ, r_rd_lo};
      end else if (w_start && wr_en && r_buf_vld && (r_buf_w == w_word)) begin
        r_buf_data <= write_data;
      end
    end
  end
`endif

  assign ready = (r_state == ST_DONE) | ((r_state == ST_IDLE) & ~rd_en & ~wr_en);

  assign read_data = r_read_data;
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_UB_N = r_ce_n;
  assign SRAM_LB_N = r_ce_n;
  assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'hzzzz;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: directed bench for mem_sram_ctrl. It runs a table of load
// and store accesses against a small behavioural SRAM, followed by
// hand-written sequences for reset in mid-access, request hold-over, and the
// optional read buffer (SRAM_READ_BUFFER_EN).
module tb_mem_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  int n_checks = 0;
  int n_fail   = 0;

  mem_sram_ctrl #(.ADDR_BASE(32'd1024), .PHASE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_OE_N  (sram_oe_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM (64 half-words); words 1 and 2 preloaded on reset
  logic [15:0] mem [0:63];
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (rst) begin
      mem[2] <= 16'h2222;
      mem[3] <= 16'h1111;
      mem[4] <= 16'h4444;
      mem[5] <= 16'h3333;
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
    end
  end

`ifdef SRAM_READ_BUFFER_EN
  localparam int HIT_FREEZE = 1;
  localparam int HIT_CE     = 0;
`else
  localparam int HIT_FREEZE = 5;
  localparam int HIT_CE     = 4;
`endif

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_freeze;
    int          exp_we;
    int          exp_ce;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One access; returns in the DONE cycle (ready high) with the request still applied
  task automatic do_access(input bit adv, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input int exp_fr,
                           input int exp_we, input int exp_ce, input string tag);
    int fr, we, ce;
    bit done;
    if (adv) begin
      @(posedge clk);
      #1;
    end
    rd_en = rd;
    wr_en = wr;
    address = a;
    write_data = wd;
    fr = 0;
    we = 0;
    ce = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (ready) begin
        done = 1'b1;
      end else begin
        fr++;
        if (!sram_we_n) we++;
        if (!sram_ce_n) ce++;
        @(posedge clk);
        #1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: ready never returned, got %0d freeze cycles", tag, fr);
    end
    chk({tag, "_freeze"}, 32'(fr), 32'(exp_fr));
    chk({tag, "_we_cycles"}, 32'(we), 32'(exp_we));
    chk({tag, "_ce_cycles"}, 32'(ce), 32'(exp_ce));
    chk({tag, "_read_data"}, read_data, exp_rd);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 5, 4, 4};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 5, 0, 4};
    vecs[2] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h11112222, 5, 0, 4};
    vecs[3] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h33334444, 5, 0, 4};
    vecs[4] = '{1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 32'h33334444, 5, 4, 4};
    vecs[5] = '{1'b1, 1'b0, 32'd1036, 32'h0,        32'hCAFEF00D, 5, 0, 4};

    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = 32'd0;
    write_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state with no request
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_n_ctrls", 32'({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}), 32'h1f);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);

    // Table: write, read-back, back-to-back reads, rd+wr treated as write
    for (int i = 0; i < 6; i++) begin
      do_access(1'b1, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_freeze, vecs[i].exp_we,
                vecs[i].exp_ce, $sformatf("vec%0d", i));
    end
    chk("mem0_lo", 32'(mem[0]), 32'h0000BEEF);
    chk("mem1_hi", 32'(mem[1]), 32'h0000DEAD);
    chk("mem6_lo", 32'(mem[6]), 32'h0000F00D);
    chk("mem7_hi", 32'(mem[7]), 32'h0000CAFE);

    // Reset asserted in the middle of the LO phase of a read
    @(posedge clk);
    #1;
    rd_en = 1'b1;
    wr_en = 1'b0;
    address = 32'd1028;
    @(posedge clk);
    #1;
    chk("midlo_ce_n", 32'(sram_ce_n), 32'd0);
    chk("midlo_oe_n", 32'(sram_oe_n), 32'd0);
    chk("midlo_addr", 32'(sram_addr), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midlo_rst_read_data", read_data, 32'd0);
    chk("midlo_rst_ctrls", 32'({sram_we_n, sram_oe_n, sram_ce_n}), 32'h7);
    chk("midlo_rst_addr", 32'(sram_addr), 32'd0);
    rst = 1'b0;
    do_access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 32'h11112222, 5, 0, 4, "post_rst_read");

    // Read 1024 twice; request held past DONE re-enters as a new access
    do_access(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5, 0, 4, "buf_fill");
    @(posedge clk);
    #1;
    chk("held_req_ready_low", 32'(ready), 32'd0);
    do_access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, HIT_FREEZE, 0, HIT_CE, "buf_hit");

    // Write to the buffered word, then read it back
    do_access(1'b1, 1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, 5, 4, 4, "buf_wr");
    chk("buf_wr_we_released", 32'(sram_we_n), 32'd1);
    do_access(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678, HIT_FREEZE, 0, HIT_CE, "buf_rd_after_wr");

    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("final_idle_ready", 32'(ready), 32'd1);
    chk("final_read_data_hold", read_data, 32'h12345678);
    chk("final_mem0", 32'(mem[0]), 32'h00005678);
    chk("final_mem1", 32'(mem[1]), 32'h00001234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Multicycle data-memory responder for the MEM stage: accepts one 32-bit load/store request per access and performs it as two 16-bit transfers on an external asynchronous SRAM. It asserts `ready` low while busy. The pipeline derives `freeze = ~ready` and holds every stage register, including the MEM/WB register's `MEM_read_value`, until `ready` returns high. `read_data` is valid while `ready` is high after a read access.

## Interface
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `PHASE_CYCLES`, 2: cycles per 16-bit SRAM transfer; legal range 1..7.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_en` in 1: load request (MEM_R_EN); held by the frozen pipeline until `ready`.
- `wr_en` in 1: store request (MEM_W_EN); same hold rule.
- `address` in 32: byte address; bits [1:0] ignored.
- `write_data` in 32: store data.
- `read_data` out 32: load result.
- `ready` out 1: combinational; low = freeze pipeline.
- `SRAM_DQ` inout 16: SRAM data bus, high-Z unless writing.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: active-low SRAM controls.

## Operation
- Word index `w = (address - ADDR_BASE) >> 2`, truncated to 17 bits.
  - Low half-word is at `SRAM_ADDR = {w,1'b0}` and holds bits [15:0].
  - High half-word is at `{w,1'b1}` and holds bits [31:16].
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if `wr_en | rd_en`, latch the operation, `w` and `write_data`, then go to LO. Otherwise stay.
  - LO: drive the low half-word for `PHASE_CYCLES` cycles, using a 3-bit phase counter. Go to HI.
  - HI: same for the high half-word, then go to DONE.
  - DONE: one cycle, then IDLE unconditionally. The pipeline advances at the end of DONE, so IDLE never re-serves the same request.
- `wr_en` and `rd_en` both high: treated as a write.
- `ready = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en)`.
- Read access:
  - `SRAM_OE_N=0` in LO/HI.
  - `SRAM_DQ` is sampled on the last cycle of each phase into `read_data[15:0]` (LO) and `read_data[31:16]` (HI).
- Write access:
  - `SRAM_WE_N=0` and `SRAM_DQ` driven in LO/HI, with the matching half of the latched `write_data`.
  - `read_data` is unchanged.
- `SRAM_CE_N`, `SRAM_UB_N` and `SRAM_LB_N` are 0 in LO/HI and 1 otherwise.
- `SRAM_ADDR` is registered and held from its phase until the next access.
- `read_data` holds its value until the next completed read.
- Reset values:
  - state IDLE, phase counter 0.
  - `read_data` = 0, `SRAM_ADDR` = 0.
  - all `_N` controls = 1, `SRAM_DQ` high-Z.
  - `ready` = 1 when there is no request.
- Reset mid-access: the access is abandoned at that edge and no partial `read_data` update survives.
  - The SRAM word may hold a torn write.
  - A request still asserted after reset starts a fresh access.

## Timing
- Request first visible in IDLE cycle t:
  - `ready` = 0 in cycles t .. t+2·PHASE_CYCLES.
  - `ready` = 1 in cycle t+2·PHASE_CYCLES+1 (DONE).
  - Default: 5 freeze cycles.
- A back-to-back request, seen in the IDLE cycle right after DONE, begins immediately. There is no idle gap beyond IDLE itself.
- `read_data` is stable from the DONE cycle onward.
- Write and output enables change only on clock edges. `SRAM_DQ` drive is released in the cycle WE_N returns to 1.

## Configuration
- `SRAM_READ_BUFFER_EN` defined: adds a one-entry buffer (valid, 17-bit `w`, 32-bit data).
  - Filled by every completed read.
  - A write to the buffered `w` updates the buffer data with `write_data`.
  - A read whose `w` matches a valid entry goes IDLE→DONE directly: 1 freeze cycle, no SRAM activity, `read_data` taken from the buffer.
  - `rst` clears valid.
- Not defined: every read performs the full LO/HI sequence and there is no buffer logic.

## Test plan
- Reset, no request → `ready`=1, `read_data`=0, all `_N`=1, DQ high-Z. Also check with `rst` asserted mid-LO.
- Write 0xDEADBEEF to address 1024 → 5 cycles `ready`=0, then SRAM[0]=0xBEEF and SRAM[1]=0xDEAD, `WE_N` low for 4 cycles.
- Read address 1024 after that write → `read_data`=0xDEADBEEF in the DONE cycle, `ready` high exactly 1 cycle.
- Back-to-back reads of 1028 then 1032 (model holds 0x11112222, 0x33334444) → two separate 5-cycle freezes, with correct data in each DONE.
- `rd_en`=`wr_en`=1 at 1036 with data 0xCAFEF00D → write performed, `read_data` unchanged.
- With `SRAM_READ_BUFFER_EN`: read 1024 twice → second access has 1 freeze cycle and no CE_N activity. Then write 0x12345678 to 1024 and read again → buffered 0x12345678.
